// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and parity helper
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DATA,
    PARITY,
    STOP,
    BREAK
  } rx_state_t;

  localparam int unsigned MAX_DATA_WIDTH = 15;

  // Callers zero-extend narrower words; the extra zeros do not change parity.
  function automatic logic even_parity(input logic [MAX_DATA_WIDTH-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - serial line in, received word stream out
interface uart_rx_if #(
  parameter int DATA_WIDTH = 8
);

  logic                  rx;
  logic                  parity;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  valid;
  logic                  ready;
  logic                  parity_err;
  logic                  frame_err;
  logic                  overrun;

  modport master (
    output rx, parity, ready,
    input  rx_data, valid, parity_err, frame_err, overrun
  );

  modport slave (
    input  rx, parity, ready,
    output rx_data, valid, parity_err, frame_err, overrun
  );

endinterface

// File: rtl/uart_sync.sv
// rtl/uart_sync.sv - N-flop bit synchroniser, resets to 1
module uart_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES:0]   chain;

  assign chain = {sync_q, d_i};

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '1;
    end else begin
      sync_q <= chain[STAGES-1:0];
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - one-cycle-per-bit UART deframer with one-entry output register
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input logic      clk,
  input logic      rst,
  uart_rx_if.slave bus
);

  logic rx_s;

  uart_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (bus.rx),
    .q_o (rx_s)
  );

  rx_state_t             state_q, state_d;
  logic [3:0]            bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  par_en_q, par_en_d;
  logic                  perr_q, perr_d;
  logic [DATA_WIDTH:0]   shift_cat;

  logic                  frame_done;
  logic                  frame_perr;
  logic                  frame_ferr;

  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  perr_out_q, perr_out_d;
  logic                  ferr_q, ferr_d;
  logic                  overrun_q, overrun_d;

  assign shift_cat = {rx_s, shift_q};

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    par_en_d   = par_en_q;
    perr_d     = perr_q;
    frame_done = 1'b0;
    frame_perr = 1'b0;
    frame_ferr = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d   = DATA;
          bit_cnt_d = 4'(DATA_WIDTH);
          par_en_d  = bus.parity;
          perr_d    = 1'b0;
        end
      end
      DATA: begin
        shift_d   = shift_cat[DATA_WIDTH:1];
        bit_cnt_d = bit_cnt_q - 4'd1;
        if (bit_cnt_q == 4'd1) begin
          state_d = par_en_q ? PARITY : STOP;
        end
      end
      PARITY: begin
        perr_d  = even_parity(MAX_DATA_WIDTH'(shift_q)) ^ rx_s;
        state_d = STOP;
      end
      STOP: begin
        frame_done = 1'b1;
        frame_ferr = ~rx_s;
        frame_perr = par_en_q & perr_q;
        state_d    = rx_s ? IDLE : BREAK;
      end
      BREAK: begin
        // A held-low line yields one bad frame, then waits for idle.
        if (rx_s) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    data_d     = data_q;
    valid_d    = valid_q;
    perr_out_d = perr_out_q;
    ferr_d     = ferr_q;
    overrun_d  = 1'b0;
    if (frame_done) begin
      if (!valid_q || bus.ready) begin
        data_d     = shift_q;
        perr_out_d = frame_perr;
        ferr_d     = frame_ferr;
        valid_d    = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && bus.ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      par_en_q   <= 1'b0;
      perr_q     <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      perr_out_q <= 1'b0;
      ferr_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      par_en_q   <= par_en_d;
      perr_q     <= perr_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      perr_out_q <= perr_out_d;
      ferr_q     <= ferr_d;
      overrun_q  <= overrun_d;
    end
  end

  assign bus.rx_data    = data_q;
  assign bus.valid      = valid_q;
  assign bus.parity_err = perr_out_q;
  assign bus.frame_err  = ferr_q;
  assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx
module tb_uart_rx;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_rx_if #(.DATA_WIDTH(W)) bus ();

  uart_rx #(.DATA_WIDTH(W), .SYNC_STAGES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [W-1:0] data;
    logic         perr;
    logic         ferr;
  } word_t;

  typedef struct {
    logic [W-1:0] data;
    logic         pm;
    logic         pb;
    logic         sb;
    int           hold_low;
    logic [W-1:0] exp_data;
    logic         exp_perr;
    logic         exp_ferr;
  } vec_t;

  word_t got[$];
  word_t exp_q[$];
  int    errors = 0;
  int    checks = 0;
  int    edge_n = 0;
  int    ovr_cnt = 0;
  int    valid_obs = 0;
  int    first_valid = -1;
  int    rdy_mode = 0;
  int    rdy_edge = -1;
  int    sb_deliv = 0;
  bit    sb_on = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, req, edge_n);
    end
  endtask

  function automatic word_t model(input logic [W-1:0] d, input logic pm, input logic pb,
                                  input logic sb);
    word_t m;
    m.data = d;
    m.perr = pm && (pb != (^d));
    m.ferr = !sb;
    return m;
  endfunction

  // Observe the state left by the previous edge, then drive the next bit.
  task automatic step(input logic rx_v);
    word_t w;
    word_t e;
    logic  r;
    if (bus.overrun) begin
      ovr_cnt++;
      if (sb_on) begin
        check("overrun_has_victim", 32'(exp_q.size() >= 2), 1);
        if (exp_q.size() >= 2) exp_q.delete(1);
      end
    end
    if (bus.valid) begin
      valid_obs++;
      if (first_valid < 0) first_valid = edge_n;
    end
    case (rdy_mode)
      0:       r = 1'b0;
      1:       r = 1'b1;
      2:       r = 1'($urandom_range(0, 1));
      default: r = (edge_n + 1 == rdy_edge);
    endcase
    if (bus.valid && r) begin
      w.data = bus.rx_data;
      w.perr = bus.parity_err;
      w.ferr = bus.frame_err;
      if (sb_on) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected_word", 1, 0);
        end else begin
          e = exp_q.pop_front();
          sb_deliv++;
          check("sb_data", 32'(w.data), 32'(e.data));
          check("sb_parity_err", 32'(w.perr), 32'(e.perr));
          check("sb_frame_err", 32'(w.ferr), 32'(e.ferr));
        end
      end else begin
        got.push_back(w);
      end
    end
    bus.ready = r;
    bus.rx    = rx_v;
    @(posedge clk);
    edge_n++;
    #1;
  endtask

  task automatic send_frame(input logic [W-1:0] d, input logic pm, input logic pb,
                            input logic sb, input bit rand_par, output int start_edge);
    bus.parity = pm;
    start_edge = edge_n + 1;
    step(1'b0);
    for (int i = 0; i < W; i++) begin
      if (rand_par && i >= 3) bus.parity = 1'($urandom_range(0, 1));
      step(d[i]);
    end
    if (pm) step(pb);
    step(sb);
  endtask

  vec_t vecs[9];
  int   s_edge;
  int   ovr0;

  initial begin
    vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b1, 0,  8'hA5, 1'b0, 1'b0};
    vecs[1] = '{8'h07, 1'b1, 1'b1, 1'b1, 0,  8'h07, 1'b0, 1'b0};
    vecs[2] = '{8'h00, 1'b1, 1'b0, 1'b1, 0,  8'h00, 1'b0, 1'b0};
    vecs[3] = '{8'h07, 1'b1, 1'b0, 1'b1, 0,  8'h07, 1'b1, 1'b0};
    vecs[4] = '{8'h3C, 1'b0, 1'b0, 1'b0, 20, 8'h3C, 1'b0, 1'b1};
    vecs[5] = '{8'h81, 1'b0, 1'b0, 1'b1, 0,  8'h81, 1'b0, 1'b0};
    vecs[6] = '{8'h01, 1'b1, 1'b0, 1'b1, 0,  8'h01, 1'b1, 1'b0};
    vecs[7] = '{8'hFE, 1'b1, 1'b1, 1'b1, 0,  8'hFE, 1'b0, 1'b0};
    vecs[8] = '{8'h3C, 1'b1, 1'b0, 1'b0, 0,  8'h3C, 1'b0, 1'b1};

    rst        = 1'b1;
    bus.rx     = 1'b1;
    bus.parity = 1'b0;
    bus.ready  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_valid", 32'(bus.valid), 0);
    check("reset_rx_data", 32'(bus.rx_data), 0);
    check("reset_parity_err", 32'(bus.parity_err), 0);
    check("reset_frame_err", 32'(bus.frame_err), 0);
    check("reset_overrun", 32'(bus.overrun), 0);
    rst = 1'b0;
    repeat (3) step(1'b1);

    // Table of single frames with ready held high.
    rdy_mode = 1;
    for (int v = 0; v < 9; v++) begin
      got.delete();
      valid_obs   = 0;
      first_valid = -1;
      send_frame(vecs[v].data, vecs[v].pm, vecs[v].pb, vecs[v].sb, 1'b0, s_edge);
      repeat (vecs[v].hold_low) step(1'b0);
      repeat (4) step(1'b1);
      check("vec_count", 32'(got.size()), 1);
      if (got.size() > 0) begin
        check("vec_data", 32'(got[0].data), 32'(vecs[v].exp_data));
        check("vec_parity_err", 32'(got[0].perr), 32'(vecs[v].exp_perr));
        check("vec_frame_err", 32'(got[0].ferr), 32'(vecs[v].exp_ferr));
      end
      check("vec_valid_cycles", 32'(valid_obs), 1);
      check("vec_latency", 32'(first_valid - s_edge), 32'(2 + W + 1 + int'(vecs[v].pm)));
    end

    // Overrun: second word dropped while the first is held.
    got.delete();
    ovr0     = ovr_cnt;
    rdy_mode = 0;
    send_frame(8'h11, 1'b0, 1'b0, 1'b1, 1'b0, s_edge);
    repeat (4) step(1'b1);
    send_frame(8'h22, 1'b0, 1'b0, 1'b1, 1'b0, s_edge);
    repeat (4) step(1'b1);
    check("ovr_held_data", 32'(bus.rx_data), 32'h11);
    check("ovr_held_valid", 32'(bus.valid), 1);
    check("ovr_pulses", 32'(ovr_cnt - ovr0), 1);
    check("ovr_none_taken", 32'(got.size()), 0);
    rdy_mode = 1;
    repeat (2) step(1'b1);
    check("ovr_drain_count", 32'(got.size()), 1);
    if (got.size() > 0) check("ovr_drain_data", 32'(got[0].data), 32'h11);
    check("ovr_valid_drops", 32'(bus.valid), 0);

    // Completion coinciding with a drain: no overrun.
    got.delete();
    ovr0     = ovr_cnt;
    rdy_mode = 0;
    send_frame(8'h33, 1'b0, 1'b0, 1'b1, 1'b0, s_edge);
    repeat (4) step(1'b1);
    rdy_edge = edge_n + 1 + 2 + W + 1;
    rdy_mode = 3;
    send_frame(8'h44, 1'b0, 1'b0, 1'b1, 1'b0, s_edge);
    repeat (4) step(1'b1);
    rdy_mode = 1;
    repeat (2) step(1'b1);
    check("same_cycle_overrun", 32'(ovr_cnt - ovr0), 0);
    check("same_cycle_count", 32'(got.size()), 2);
    if (got.size() == 2) begin
      check("same_cycle_first", 32'(got[0].data), 32'h33);
      check("same_cycle_second", 32'(got[1].data), 32'h44);
    end

    // Reset in the middle of 0xFF while a word is held.
    got.delete();
    rdy_mode = 0;
    send_frame(8'h66, 1'b0, 1'b0, 1'b1, 1'b0, s_edge);
    repeat (4) step(1'b1);
    step(1'b0);
    repeat (4) step(1'b1);
    rst = 1'b1;
    step(1'b1);
    rst = 1'b0;
    check("midrst_valid", 32'(bus.valid), 0);
    check("midrst_rx_data", 32'(bus.rx_data), 0);
    check("midrst_parity_err", 32'(bus.parity_err), 0);
    check("midrst_frame_err", 32'(bus.frame_err), 0);
    check("midrst_overrun", 32'(bus.overrun), 0);
    repeat (6) step(1'b1);
    rdy_mode = 1;
    send_frame(8'h5A, 1'b0, 1'b0, 1'b1, 1'b0, s_edge);
    repeat (4) step(1'b1);
    check("midrst_count", 32'(got.size()), 1);
    if (got.size() > 0) check("midrst_data", 32'(got[0].data), 32'h5A);

    // Random back-to-back stream against the scoreboard.
    sb_on    = 1'b1;
    rdy_mode = 2;
    ovr0     = ovr_cnt;
    for (int n = 0; n < 1000; n++) begin
      logic [W-1:0] d;
      logic         pm;
      logic         pb;
      logic         sb;
      d  = W'($urandom);
      pm = 1'($urandom_range(0, 1));
      pb = (^d) ^ ($urandom_range(0, 7) == 0);
      sb = ($urandom_range(0, 15) != 0);
      exp_q.push_back(model(d, pm, pb, sb));
      send_frame(d, pm, pb, sb, 1'b1, s_edge);
      if (!sb) step(1'b1);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) step(1'b1);
    end
    rdy_mode = 1;
    repeat (30) step(1'b1);
    check("sb_drained", 32'(exp_q.size()), 0);
    check("sb_accounting", 32'(sb_deliv + (ovr_cnt - ovr0)), 1000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver that consumes the line driven by `uart_tx`: idle high, one start bit (0), DATA_WIDTH data bits LSB first, optional even-parity bit, and one stop bit (1). Each bit lasts exactly one `clk` cycle, so there is no baud divider or oversampling. The block synchronises the incoming line, deframes each word, and checks parity and stop bit. It presents the word on a valid/ready output with a one-entry holding register, plus error sidebands.

## Interface
- DATA_WIDTH, 8, data bits per frame (1–15).
- SYNC_STAGES, 2, flops in the `rx` input synchroniser (≥1).

- clk  input  1  clock; single clock domain.
- rst  input  1  reset; synchronous and active-high.
- rx  input  1  serial line; idle high.
- parity  input  1  1 = frame carries an even-parity bit; sampled at start-bit detection and held for the frame.
- rx_data  output  DATA_WIDTH  received word; stable while `valid`.
- valid  output  1  holding register full.
- ready  input  1  consumer accepts; transfer occurs on `valid && ready`.
- parity_err  output  1  qualified by `valid`; parity check failed for `rx_data`.
- frame_err  output  1  qualified by `valid`; stop bit sampled 0.
- overrun  output  1  one-cycle pulse; a completed frame was dropped.

## Operation
- `rx_s` is `rx` after SYNC_STAGES flops. All decisions below use `rx_s`.
- IDLE: when `rx_s==0`:
  - go to DATA;
  - load `bit_cnt=DATA_WIDTH`;
  - latch `parity` into `par_en`.
- DATA: each cycle, shift `rx_s` into the MSB of the shift register (shifting right) and decrement `bit_cnt`.
  - When the last data bit is taken, go to PARITY if `par_en`, otherwise STOP.
  - After DATA_WIDTH shifts, bit 0 holds the first data bit received.
- PARITY: `perr = ^shift ^ rx_s`, where 1 means an error. Go to STOP.
- STOP: complete the frame.
  - `ferr = ~rx_s`; `perr` is forced to 0 when `par_en==0`.
  - If `rx_s==1`, go to IDLE.
  - Otherwise go to BREAK.
- BREAK: wait for `rx_s==1`, then go to IDLE. A held-low line (break or stuck line) produces exactly one erroneous frame, not a stream of frames.
- Frame completion with the holding register free, or being drained in the same cycle (`valid && ready`): load `rx_data`, `parity_err`, `frame_err`; hold `valid=1`.
- Frame completion while `valid && !ready`:
  - the new frame is discarded;
  - the old word and flags are kept;
  - `overrun` pulses 1 for one cycle.
- `valid` clears on `valid && ready` when no frame completes in that cycle.
- Bad frames (`ferr` or `perr`) are still delivered, with the corresponding flag set.

## Timing
- Reset values:
  - `valid=0`, `rx_data=0`, `parity_err=0`, `frame_err=0`, `overrun=0`;
  - synchroniser flops = 1;
  - state IDLE.
- Reset mid-frame abandons the partial word; nothing is delivered for it.
- Latency: call the edge that samples `rx_s==0` in IDLE edge k.
  - Data bits are sampled on edges k+1 … k+DATA_WIDTH.
  - Parity, when enabled, is sampled on edge k+DATA_WIDTH+1.
  - Stop is sampled on the next edge after that, and `valid` rises on that same edge.
  - Pin-to-`rx_s` adds SYNC_STAGES cycles.
- Back-to-back frames: a start bit on the cycle right after a good stop bit (state IDLE) is accepted. There are no dead cycles.
- `ready` may be held high permanently. `valid` is then high for one cycle per frame.
- `parity` changing mid-frame has no effect on the current frame.

## Structure
- `uart_pkg`:
  - `rx_state_t` enum (IDLE, DATA, PARITY, STOP, BREAK);
  - `even_parity()` function, shared with `uart_tx`'s parity computation.
- Sub-module `uart_sync`: parameterised N-flop bit synchroniser with synchronous reset value 1. It is also reusable for other asynchronous inputs.
- Rest of the block: one FSM, a 4-bit counter, a shift register, and the output holding register.

## Test plan
- Loopback from `uart_tx` (DATA_WIDTH=8, parity=0), sending 0xA5 with `ready=1` -> `valid` for one cycle, `rx_data=0xA5`, no errors, latency as specified above.
- Loopback with parity=1: send 0x07 (parity bit 1) then 0x00 -> both words received, `parity_err=0`. Flip the parity bit of 0x07 on the line -> 0x07 delivered with `parity_err=1`.
- Drive 0x3C frame with stop=0, then hold `rx` low for 20 cycles, then high, then send 0x81 -> exactly one frame 0x3C with `frame_err=1`, then 0x81 clean.
- `ready=0`, send 0x11 then 0x22 -> `rx_data` stays 0x11 and `overrun` pulses once. Raise `ready` -> 0x11 transferred and `valid` drops. Completion with `ready=1` in the same cycle -> no overrun.
- Assert `rst` for 1 cycle at data bit 4 of 0xFF, then send 0x5A -> only 0x5A is received, and all outputs read their reset values in the cycle after reset.
- Random back-to-back stream of 1000 words with random parity mode and random `ready` -> scoreboard matches the sent words; every dropped word coincides with an `overrun` pulse.
